// File: rtl/moving_average_multich.sv
// Multi-channel boxcar mean: one shared delay-line RAM plus per-channel accumulators, 3-cycle pipeline.
// Optional MOVING_AVG_MULTICH_ROUND_EN: round-half-up with positive saturation in the scale step.
module moving_average_multich #(
    parameter int DIN_WIDTH    = 25,
    parameter int DIN_POINT    = 24,
    parameter int DOUT_WIDTH   = 25,
    parameter int N_CHANNELS   = 4,
    parameter int MAX_WIN_LOG2 = 7,
    localparam int WL_W = $clog2(MAX_WIN_LOG2 + 1),
    localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_valid,
    input  logic                  din_sync,
    input  logic [WL_W-1:0]       win_log2,
    input  logic                  win_load,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [CH_W-1:0]       dout_ch,
    output logic                  dout_full
);
    localparam int PTR_W  = MAX_WIN_LOG2;
    localparam int DEPTH  = N_CHANNELS << MAX_WIN_LOG2;
    localparam int AW     = $clog2(DEPTH);
    localparam int ACC_W  = DIN_WIDTH + MAX_WIN_LOG2;
    localparam int DROP   = DIN_WIDTH - DOUT_WIDTH;
    localparam int FILL_W = MAX_WIN_LOG2 + 1;

    if (DOUT_WIDTH > DIN_WIDTH || DIN_POINT >= DIN_WIDTH || N_CHANNELS < 1 || N_CHANNELS > 64
        || MAX_WIN_LOG2 < 1) begin : g_param_check
        $error("moving_average_multich: unsupported parameter combination");
    end

    function automatic logic signed [DOUT_WIDTH-1:0] scale_mean(input logic signed [ACC_W-1:0] acc,
                                                                input logic [WL_W-1:0] wl);
        int                     sh;
        logic signed [ACC_W:0]  ext;
        sh  = int'(wl) + DROP;
        ext = {acc[ACC_W-1], acc};
`ifdef MOVING_AVG_MULTICH_ROUND_EN
        begin
            logic signed [ACC_W:0] max_pos;
            max_pos = {{(ACC_W - DOUT_WIDTH + 2){1'b0}}, {(DOUT_WIDTH - 1){1'b1}}};
            if (sh > 0) ext = ext + ((ACC_W + 1)'(1) << (sh - 1));
            ext = ext >>> sh;
            if (ext > max_pos) ext = max_pos;
        end
`else
        ext = ext >>> sh;
`endif
        return DOUT_WIDTH'(ext);
    endfunction

    logic [WL_W-1:0]              win_q, win_d;
    logic [CH_W-1:0]              ch_cnt_q, ch_cnt_d, ch_cur;
    logic [PTR_W-1:0]             ptr_q, ptr_d, rd_ptr;
    logic [FILL_W-1:0]            fill_q, fill_d, win_len;
    logic [AW-1:0]                wr_addr, rd_addr;
    logic                         accept, last_ch;

    logic                         vld_p1_q, vld_p1_d, old_ok_p1_q, old_ok_p1_d, full_p1_q, full_p1_d;
    logic [CH_W-1:0]              ch_p1_q, ch_p1_d;
    logic signed [DIN_WIDTH-1:0]  din_p1_q, din_p1_d, ram_rd_q, old_s;
    logic signed [DIN_WIDTH-1:0]  mem [DEPTH];

    logic                         vld_p2_q, vld_p2_d, full_p2_q, full_p2_d;
    logic [CH_W-1:0]              ch_p2_q, ch_p2_d;
    logic signed [ACC_W-1:0]      sum_p2_q, sum_p2_d, sum_s;
    logic signed [ACC_W-1:0]      acc_q [N_CHANNELS];
    logic signed [ACC_W-1:0]      acc_d [N_CHANNELS];

    logic                         dout_vld_q, dout_vld_d, dout_full_q, dout_full_d;
    logic [CH_W-1:0]              dout_ch_q, dout_ch_d;
    logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;

    // Stage 0: channel/pointer/fill bookkeeping and RAM addressing
    always_comb begin
        win_len  = FILL_W'(1) << win_q;
        ch_cur   = (din_valid && din_sync) ? '0 : ch_cnt_q;
        accept   = din_valid && !win_load;
        last_ch  = (ch_cur == CH_W'(N_CHANNELS - 1));
        rd_ptr   = ptr_q - PTR_W'(win_len);
        wr_addr  = (AW'(ch_cur) << PTR_W) | AW'(ptr_q);
        rd_addr  = (AW'(ch_cur) << PTR_W) | AW'(rd_ptr);
        win_d    = win_q;
        ch_cnt_d = ch_cnt_q;
        ptr_d    = ptr_q;
        fill_d   = fill_q;
        if (win_load) begin
            win_d    = (int'(win_log2) > MAX_WIN_LOG2) ? WL_W'(MAX_WIN_LOG2) : win_log2;
            ch_cnt_d = '0;
            ptr_d    = '0;
            fill_d   = '0;
        end else if (accept) begin
            if (last_ch) begin
                ch_cnt_d = '0;
                ptr_d    = ptr_q + PTR_W'(1);
                if (fill_q < win_len) fill_d = fill_q + FILL_W'(1);
            end else begin
                ch_cnt_d = ch_cur + CH_W'(1);
            end
        end
        vld_p1_d    = accept;
        ch_p1_d     = ch_cur;
        din_p1_d    = din;
        old_ok_p1_d = (fill_q >= win_len);
        full_p1_d   = (fill_q >= win_len - FILL_W'(1));
    end

    // Stage 1 -> 2: accumulator read-modify-write in one stage, so no same-channel bypass
    always_comb begin
        old_s = old_ok_p1_q ? ram_rd_q : '0;
        sum_s = acc_q[ch_p1_q] + ACC_W'(din_p1_q) - ACC_W'(old_s);
        for (int i = 0; i < N_CHANNELS; i++) acc_d[i] = win_load ? '0 : acc_q[i];
        if (!win_load && vld_p1_q) acc_d[ch_p1_q] = sum_s;
        vld_p2_d  = vld_p1_q && !win_load;
        ch_p2_d   = ch_p1_q;
        full_p2_d = full_p1_q;
        sum_p2_d  = sum_s;
    end

    // Stage 2 -> 3: scale and output register, holding when nothing valid arrives
    always_comb begin
        dout_vld_d  = vld_p2_q && !win_load;
        dout_d      = dout_q;
        dout_ch_d   = dout_ch_q;
        dout_full_d = dout_full_q;
        if (dout_vld_d) begin
            dout_d      = scale_mean(sum_p2_q, win_q);
            dout_ch_d   = ch_p2_q;
            dout_full_d = full_p2_q;
        end
    end

    // Read-first RAM: the registered read returns the pre-write contents on address collision
    always_ff @(posedge clk) begin
        if (accept) mem[wr_addr] <= din_p1_d;
        ram_rd_q <= mem[rd_addr];
        din_p1_q <= din_p1_d;
        sum_p2_q <= sum_p2_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q       <= WL_W'(MAX_WIN_LOG2);
            ch_cnt_q    <= '0;
            ptr_q       <= '0;
            fill_q      <= '0;
            vld_p1_q    <= 1'b0;
            ch_p1_q     <= '0;
            old_ok_p1_q <= 1'b0;
            full_p1_q   <= 1'b0;
            vld_p2_q    <= 1'b0;
            ch_p2_q     <= '0;
            full_p2_q   <= 1'b0;
            for (int i = 0; i < N_CHANNELS; i++) acc_q[i] <= '0;
            dout_vld_q  <= 1'b0;
            dout_q      <= '0;
            dout_ch_q   <= '0;
            dout_full_q <= 1'b0;
        end else begin
            win_q       <= win_d;
            ch_cnt_q    <= ch_cnt_d;
            ptr_q       <= ptr_d;
            fill_q      <= fill_d;
            vld_p1_q    <= vld_p1_d;
            ch_p1_q     <= ch_p1_d;
            old_ok_p1_q <= old_ok_p1_d;
            full_p1_q   <= full_p1_d;
            vld_p2_q    <= vld_p2_d;
            ch_p2_q     <= ch_p2_d;
            full_p2_q   <= full_p2_d;
            for (int i = 0; i < N_CHANNELS; i++) acc_q[i] <= acc_d[i];
            dout_vld_q  <= dout_vld_d;
            dout_q      <= dout_d;
            dout_ch_q   <= dout_ch_d;
            dout_full_q <= dout_full_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_vld_q;
    assign dout_ch    = dout_ch_q;
    assign dout_full  = dout_full_q;
endmodule
